// File: rtl/multi_alarm_clock.sv
// Multi-slot BCD alarm clock: 24h time-of-day counter with a manual set mode,
// N programmable alarm slots and a ring / snooze / stop state machine.
module multi_alarm_clock #(
  parameter int N_ALARMS   = 4,
  parameter int TICK_DIV   = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic        clk_1khz,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic        switch,
  input  logic        add,
  input  logic        alm_wr,
  input  logic [2:0]  alm_idx,
  input  logic [7:0]  alm_hh,
  input  logic [7:0]  alm_mm,
  input  logic        alm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic [31:0] out,
  output logic        ringing,
  output logic [2:0]  ring_idx
);

  localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       RING_LAST = 8'(RING_SEC - 1);
  localparam logic [1:0]       SEL_HH    = 2'd0;
  localparam logic [1:0]       SEL_MM    = 2'd1;
  localparam logic [1:0]       SEL_SS    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] last);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= last);
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(b / 7'd10);
    ones = 4'(b - 7'(tens) * 7'd10);
    return {tens, ones};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [7:0]       hh_adv, mm_adv, ss_adv;
  logic [1:0]       field_q, field_d, field_cur;
  logic             set_en_q;
  logic             sec_tick, at_minute;

  logic [7:0]       slot_hh_q [N_ALARMS];
  logic [7:0]       slot_hh_d [N_ALARMS];
  logic [7:0]       slot_mm_q [N_ALARMS];
  logic [7:0]       slot_mm_d [N_ALARMS];
  logic             slot_en_q [N_ALARMS];
  logic             slot_en_d [N_ALARMS];
  logic             wr_ok;
  logic             match;
  logic [2:0]       match_idx;

  state_e           state_q, state_d;
  logic [7:0]       ring_sec_q, ring_sec_d;
  logic [2:0]       ring_idx_q, ring_idx_d;
  logic             ringing_q, ringing_d;
  logic [7:0]       tgt_hh_q, tgt_hh_d, tgt_mm_q, tgt_mm_d;
  logic [6:0]       snz_mm_bin, snz_hh_bin;
  logic             disable_hit;

  assign sec_tick  = !set_en && (cnt_q == CNT_MAX);
  assign at_minute = sec_tick && (ss_adv == 8'h00);

  // Time one second ahead of the current value, used both for counting and for matching.
  always_comb begin
    ss_adv = bcd_inc(ss_q, 8'h59);
    mm_adv = mm_q;
    hh_adv = hh_q;
    if (ss_q == 8'h59) begin
      mm_adv = bcd_inc(mm_q, 8'h59);
      if (mm_q == 8'h59) begin
        hh_adv = bcd_inc(hh_q, 8'h23);
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    field_d   = field_q;
    field_cur = (set_en && !set_en_q) ? SEL_HH : field_q;
    if (set_en) begin
      cnt_d   = '0;
      field_d = field_cur;
      if (switch) begin
        field_d = (field_cur == SEL_SS) ? SEL_HH : field_cur + 2'd1;
      end
      if (add) begin
        case (field_cur)
          SEL_HH:  hh_d = bcd_inc(hh_q, 8'h23);
          SEL_MM:  mm_d = bcd_inc(mm_q, 8'h59);
          default: ss_d = bcd_inc(ss_q, 8'h59);
        endcase
      end
    end else if (sec_tick) begin
      cnt_d = '0;
      hh_d  = hh_adv;
      mm_d  = mm_adv;
      ss_d  = ss_adv;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign wr_ok = alm_wr && (int'(alm_idx) < N_ALARMS) &&
                 bcd_ok(alm_hh, 8'h23) && bcd_ok(alm_mm, 8'h59);

  always_comb begin
    for (int i = 0; i < N_ALARMS; i++) begin
      slot_hh_d[i] = slot_hh_q[i];
      slot_mm_d[i] = slot_mm_q[i];
      slot_en_d[i] = slot_en_q[i];
      if (wr_ok && (alm_idx == 3'(i))) begin
        slot_hh_d[i] = alm_hh;
        slot_mm_d[i] = alm_mm;
        slot_en_d[i] = alm_en;
      end
    end
  end

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = 3'd0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (at_minute && slot_en_q[i] && (slot_hh_q[i] == hh_adv) && (slot_mm_q[i] == mm_adv)) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  always_comb begin
    snz_mm_bin = bcd2bin(mm_q) + 7'(SNOOZE_MIN);
    snz_hh_bin = bcd2bin(hh_q);
    if (snz_mm_bin >= 7'd60) begin
      snz_mm_bin = snz_mm_bin - 7'd60;
      snz_hh_bin = (snz_hh_bin == 7'd23) ? 7'd0 : snz_hh_bin + 7'd1;
    end
  end

  assign disable_hit = wr_ok && !alm_en && (alm_idx == ring_idx_q);

  always_comb begin
    state_d    = state_q;
    ring_sec_d = ring_sec_q;
    ring_idx_d = ring_idx_q;
    tgt_hh_d   = tgt_hh_q;
    tgt_mm_d   = tgt_mm_q;
    case (state_q)
      IDLE: begin
        if (match) begin
          state_d    = RING;
          ring_idx_d = match_idx;
          ring_sec_d = 8'd0;
        end
      end
      RING: begin
        if (stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d  = SNOOZE;
          tgt_hh_d = bin2bcd(snz_hh_bin);
          tgt_mm_d = bin2bcd(snz_mm_bin);
        end else if (sec_tick) begin
          if (ring_sec_q == RING_LAST) begin
            state_d = IDLE;
          end else begin
            ring_sec_d = ring_sec_q + 8'd1;
          end
        end
      end
      SNOOZE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (at_minute && (hh_adv == tgt_hh_q) && (mm_adv == tgt_mm_q)) begin
          state_d    = RING;
          ring_sec_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling the active slot silences it whatever else happens this cycle.
    if ((state_q != IDLE) && disable_hit) begin
      state_d = IDLE;
    end
    ringing_d = (state_d == RING);
  end

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      field_q    <= SEL_HH;
      set_en_q   <= 1'b0;
      state_q    <= IDLE;
      ring_sec_q <= 8'd0;
      ring_idx_q <= 3'd0;
      ringing_q  <= 1'b0;
      tgt_hh_q   <= 8'h00;
      tgt_mm_q   <= 8'h00;
      for (int i = 0; i < N_ALARMS; i++) begin
        slot_hh_q[i] <= 8'h00;
        slot_mm_q[i] <= 8'h00;
        slot_en_q[i] <= 1'b0;
      end
    end else begin
      cnt_q      <= cnt_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      field_q    <= field_d;
      set_en_q   <= set_en;
      state_q    <= state_d;
      ring_sec_q <= ring_sec_d;
      ring_idx_q <= ring_idx_d;
      ringing_q  <= ringing_d;
      tgt_hh_q   <= tgt_hh_d;
      tgt_mm_q   <= tgt_mm_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        slot_hh_q[i] <= slot_hh_d[i];
        slot_mm_q[i] <= slot_mm_d[i];
        slot_en_q[i] <= slot_en_d[i];
      end
    end
  end

  assign out      = {hh_q, mm_q, ss_q, 6'b0, field_q};
  assign ringing  = ringing_q;
  assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock; a short second (TICK_DIV=20) keeps the
// minute-scale alarm, timeout and snooze scenarios quick.
module tb_multi_alarm_clock;

  localparam int TD = 20;

  logic        clk = 1'b0;
  logic        rstN;
  logic        setEn, swIn, addIn, almWr, almEn, snoozeIn, stopIn;
  logic [2:0]  almIdx;
  logic [7:0]  almHh, almMm;
  logic [31:0] outVal;
  logic        ringingOut;
  logic [2:0]  ringIdxOut;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mark   = 0;

  multi_alarm_clock #(
    .N_ALARMS(4), .TICK_DIV(TD), .RING_SEC(60), .SNOOZE_MIN(5)
  ) dut (
    .clk_1khz(clk), .rst_n(rstN), .set_en(setEn), .switch(swIn), .add(addIn),
    .alm_wr(almWr), .alm_idx(almIdx), .alm_hh(almHh), .alm_mm(almMm), .alm_en(almEn),
    .snooze(snoozeIn), .stop(stopIn), .out(outVal), .ringing(ringingOut), .ring_idx(ringIdxOut)
  );

  always #5 clk = ~clk;

  // Cycles since reset release, counted on the same edges the DUT uses.
  always @(posedge clk) begin
    if (!rstN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sw, input logic ad, input logic sn, input logic st);
    swIn = sw; addIn = ad; snoozeIn = sn; stopIn = st;
    @(negedge clk);
    swIn = 1'b0; addIn = 1'b0; snoozeIn = 1'b0; stopIn = 1'b0;
  endtask

  task automatic writeAlarm(input logic [2:0] idx, input logic [7:0] hh, input logic [7:0] mm, input logic en);
    almWr = 1'b1; almIdx = idx; almHh = hh; almMm = mm; almEn = en;
    @(negedge clk);
    almWr = 1'b0; almIdx = 3'd0; almHh = 8'h00; almMm = 8'h00; almEn = 1'b0;
  endtask

  task automatic waitTo(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic doReset();
    rstN = 1'b0; setEn = 1'b0; swIn = 1'b0; addIn = 1'b0; snoozeIn = 1'b0; stopIn = 1'b0;
    almWr = 1'b0; almIdx = 3'd0; almHh = 8'h00; almMm = 8'h00; almEn = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    mark = 0;
  endtask

  // Only valid straight after reset: every field starts at zero.
  task automatic setTime(input int hh, input int mm, input int ss);
    setEn = 1'b1;
    @(negedge clk);
    repeat (hh) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (mm) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (ss) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    setEn = 1'b0;
    mark = cyc;
  endtask

  initial begin
    // Reset values and the first second.
    doReset();
    checkOutput("reset_out", outVal, 32'h00000000);
    checkOutput("reset_ringing", 32'(ringingOut), 32'd0);
    checkOutput("reset_ring_idx", 32'(ringIdxOut), 32'd0);
    waitTo(TD - 1);
    checkOutput("before_first_tick", outVal, 32'h00000000);
    waitTo(TD);
    checkOutput("first_tick", outVal, 32'h00000100);

    // Midnight rollover.
    doReset();
    setTime(23, 59, 59);
    checkOutput("set_235959", outVal, 32'h23595902);
    waitTo(mark + TD - 1);
    checkOutput("hold_235959", outVal, 32'h23595902);
    waitTo(mark + TD);
    checkOutput("day_wrap", outVal, 32'h00000002);

    // Two slots on the same minute, lowest index wins; auto-stop after 60 s.
    doReset();
    writeAlarm(3'd2, 8'h07, 8'h30, 1'b1);
    writeAlarm(3'd0, 8'h07, 8'h30, 1'b1);
    setTime(7, 29, 59);
    waitTo(mark + TD - 1);
    checkOutput("no_ring_early", 32'(ringingOut), 32'd0);
    waitTo(mark + TD);
    checkOutput("ring_0730", 32'(ringingOut), 32'd1);
    checkOutput("ring_idx_lowest", 32'(ringIdxOut), 32'd0);
    checkOutput("time_0730", outVal, 32'h07300002);
    waitTo(mark + 60 * TD);
    checkOutput("ring_59s", 32'(ringingOut), 32'd1);
    waitTo(mark + 61 * TD);
    checkOutput("auto_stop_60s", 32'(ringingOut), 32'd0);
    checkOutput("time_0731", outVal, 32'h07310002);

    // Snooze across midnight, then stop+snooze together goes idle.
    doReset();
    writeAlarm(3'd1, 8'h23, 8'h58, 1'b1);
    setTime(23, 57, 59);
    waitTo(mark + TD);
    checkOutput("ring_2358", 32'(ringingOut), 32'd1);
    checkOutput("ring_idx_1", 32'(ringIdxOut), 32'd1);
    waitTo(mark + 11 * TD);
    checkOutput("time_235810", outVal, 32'h23581002);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("snooze_quiet", 32'(ringingOut), 32'd0);
    waitTo(mark + 301 * TD - 1);
    checkOutput("snooze_000259", 32'(ringingOut), 32'd0);
    checkOutput("time_000259", outVal, 32'h00025902);
    waitTo(mark + 301 * TD);
    checkOutput("snooze_ring_0003", 32'(ringingOut), 32'd1);
    checkOutput("time_000300", outVal, 32'h00030002);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stop_wins", 32'(ringingOut), 32'd0);
    waitTo(mark + 601 * TD);
    checkOutput("no_resnooze_0008", 32'(ringingOut), 32'd0);

    // Rejected writes, out-of-range index, set mode while ringing, disable the ringing slot.
    doReset();
    writeAlarm(3'd1, 8'h00, 8'h01, 1'b1);
    writeAlarm(3'd1, 8'h00, 8'h60, 1'b0);
    writeAlarm(3'd1, 8'h24, 8'h00, 1'b0);
    writeAlarm(3'd1, 8'h00, 8'h0A, 1'b0);
    writeAlarm(3'd5, 8'h00, 8'h02, 1'b1);
    waitTo(60 * TD - 1);
    checkOutput("no_ring_000059", 32'(ringingOut), 32'd0);
    waitTo(60 * TD);
    checkOutput("bad_writes_ignored", 32'(ringingOut), 32'd1);
    checkOutput("ring_idx_slot1", 32'(ringIdxOut), 32'd1);
    setEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("set_keeps_ring", 32'(ringingOut), 32'd1);
    checkOutput("set_freezes_time", outVal, 32'h00010000);
    setEn = 1'b0;
    mark = cyc;
    writeAlarm(3'd1, 8'h00, 8'h01, 1'b0);
    checkOutput("disable_forces_idle", 32'(ringingOut), 32'd0);
    waitTo(mark + 60 * TD);
    checkOutput("idx5_ignored", 32'(ringingOut), 32'd0);
    checkOutput("time_000200", outVal, 32'h00020000);

    // Set-mode field wrap and field selection rules.
    doReset();
    setEn = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (61) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mm_add61", outVal, 32'h00010001);
    repeat (3 * TD) @(negedge clk);
    checkOutput("set_frozen", outVal, 32'h00010001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("field_wrap_hh", outVal, 32'h00010000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    setEn = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("switch_ignored", outVal, 32'h00010001);
    setEn = 1'b1;
    @(negedge clk);
    checkOutput("field_reset_on_set", outVal, 32'h00010000);
    setEn = 1'b0;

    // Reset while ringing dominates all inputs.
    doReset();
    writeAlarm(3'd3, 8'h00, 8'h01, 1'b1);
    setTime(0, 0, 59);
    waitTo(mark + TD);
    checkOutput("ring_slot3", 32'(ringIdxOut), 32'd3);
    rstN = 1'b0; addIn = 1'b1; snoozeIn = 1'b1;
    @(negedge clk);
    checkOutput("reset_drops_ring", 32'(ringingOut), 32'd0);
    checkOutput("reset_clears_out", outVal, 32'h00000000);
    checkOutput("reset_clears_idx", 32'(ringIdxOut), 32'd0);
    rstN = 1'b1; addIn = 1'b0; snoozeIn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
